decode_stage: RTL

//  Pipeline stage directly downstream of instruction fetch. Consumes the fetched word and fetch PC.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/decode_stage_reg_file.sv | 25 ++
 rtl/decode_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, functs, ALU op codes and control-word layout shared by the decode stage.
package mips_pkg;
    localparam logic [31:0] NOP = 32'h0;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_LUI = 4'd8
    } alu_op_e;
    localparam int CTRL_REG_WRITE  = 11;
    localparam int CTRL_MEM_READ   = 10;
    localparam int CTRL_MEM_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 8;
    localparam int CTRL_ALU_SRC    = 7;
    localparam int CTRL_BEQ        = 6;
    localparam int CTRL_BNE        = 5;
    localparam int CTRL_JUMP       = 4;
    localparam int CTRL_JR         = 3;
    localparam int CTRL_LINK       = 2;
    localparam int CTRL_ILLEGAL    = 1;
    localparam int CTRL_VALID      = 0;
    localparam logic [11:0] C_RW  = 12'(1) << CTRL_REG_WRITE;
    localparam logic [11:0] C_MR  = 12'(1) << CTRL_MEM_READ;
    localparam logic [11:0] C_MW  = 12'(1) << CTRL_MEM_WRITE;
    localparam logic [11:0] C_MTR = 12'(1) << CTRL_MEM_TO_REG;
    localparam logic [11:0] C_AS  = 12'(1) << CTRL_ALU_SRC;
    localparam logic [11:0] C_BEQ = 12'(1) << CTRL_BEQ;
    localparam logic [11:0] C_BNE = 12'(1) << CTRL_BNE;
    localparam logic [11:0] C_J   = 12'(1) << CTRL_JUMP;
    localparam logic [11:0] C_JR  = 12'(1) << CTRL_JR;
    localparam logic [11:0] C_LK  = 12'(1) << CTRL_LINK;
    localparam logic [11:0] C_ILL = 12'(1) << CTRL_ILLEGAL;
    localparam logic [11:0] C_V   = 12'(1) << CTRL_VALID;
endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: 2-read 1-write register file, r0 hardwired to zero, write-back bypassed onto reads.
module reg_file #(
    parameter int NREGS = 32,
    parameter int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [31:0]   wb_data,
    output logic [31:0]   rs_data,
    output logic [31:0]   rt_data
);
    logic [31:0] regs [NREGS];
    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (wb_en && wb_addr != '0)
            regs[wb_addr] <= wb_data;
    end
    assign rs_data = (rs_addr == '0) ? '0 : (wb_en && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : (wb_en && wb_addr == rt_addr) ? wb_data : regs[rt_addr];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: reads operands, decodes control and targets, and registers them into the DEC->EX stage.
module decode_stage import mips_pkg::*; #(
    parameter int PC_W = 10,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instructions,
    input  logic [PC_W-1:0] pc_FETCH,
    input  logic            stall_EX,
    input  logic [1:0]      pc_src_EX,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic [31:0]     rs_data_DEC,
    output logic [31:0]     rt_data_DEC,
    output logic [31:0]     imm_DEC,
    output logic [4:0]      rs_DEC,
    output logic [4:0]      rt_DEC,
    output logic [4:0]      rd_DEC,
    output logic [PC_W-1:0] branch_addr_DEC,
    output logic [PC_W-1:0] jtype_addr_DEC,
    output logic [PC_W-1:0] reg_addr_DEC,
    output logic [PC_W-1:0] pc_link_DEC,
    output logic [11:0]     ctrl_DEC,
    output logic [3:0]      alu_op_DEC
);
    localparam int W = 3 * 32 + 3 * 5 + 4 * PC_W + 12 + 4;
    logic [5:0] opcode, funct;
    logic [15:0] imm16;
    logic [4:0] rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [11:0] ctrl, ctrl_out;
    alu_op_e alu_op, alu_out;
    logic legal;
    logic [W-1:0] d, q;
    assign opcode = instructions[31:26];
    assign funct = instructions[5:0];
    assign imm16 = instructions[15:0];
    assign rs = instructions[25:21];
    assign rt = instructions[20:16];
    reg_file #(.NREGS(NREGS)) u_reg_file (
        .clk(clk), .rst(rst), .rs_addr(rs), .rt_addr(rt),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs_data(rs_data), .rt_data(rt_data)
    );
    always_comb begin
        ctrl = '0;
        alu_op = ALU_NOP;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE: case (funct)
                F_ADD: begin ctrl = C_RW; alu_op = ALU_ADD; end
                F_SUB: begin ctrl = C_RW; alu_op = ALU_SUB; end
                F_AND: begin ctrl = C_RW; alu_op = ALU_AND; end
                F_OR:  begin ctrl = C_RW; alu_op = ALU_OR;  end
                F_SLT: begin ctrl = C_RW; alu_op = ALU_SLT; end
                F_SLL: begin ctrl = C_RW; alu_op = ALU_SLL; end
                F_SRL: begin ctrl = C_RW; alu_op = ALU_SRL; end
                F_JR:  ctrl = C_JR;
                default: legal = 1'b0;
            endcase
            OP_ADDI: begin ctrl = C_RW | C_AS; alu_op = ALU_ADD; end
            OP_SLTI: begin ctrl = C_RW | C_AS; alu_op = ALU_SLT; end
            OP_ANDI: begin ctrl = C_RW | C_AS; alu_op = ALU_AND; end
            OP_ORI:  begin ctrl = C_RW | C_AS; alu_op = ALU_OR;  end
            OP_LUI:  begin ctrl = C_RW | C_AS; alu_op = ALU_LUI; end
            OP_LW:   begin ctrl = C_RW | C_MR | C_MTR | C_AS; alu_op = ALU_ADD; end
            OP_SW:   begin ctrl = C_MW | C_AS; alu_op = ALU_ADD; end
            OP_BEQ:  begin ctrl = C_BEQ; alu_op = ALU_SUB; end
            OP_BNE:  begin ctrl = C_BNE; alu_op = ALU_SUB; end
            OP_J:    ctrl = C_J;
            OP_JAL:  ctrl = C_RW | C_J | C_LK;
            default: legal = 1'b0;
        endcase
    end
    // Unsupported encodings still occupy a slot but must not cause any side effect downstream.
    assign ctrl_out = legal ? (ctrl | C_V) : (C_ILL | C_V);
    assign alu_out = legal ? alu_op : ALU_NOP;
    assign imm = (opcode == OP_LUI) ? {imm16, 16'h0}
               : (opcode == OP_ANDI || opcode == OP_ORI) ? {16'h0, imm16}
               : {{16{imm16[15]}}, imm16};
    assign rd = (opcode == OP_JAL) ? 5'd31 : (opcode == OP_RTYPE) ? instructions[15:11] : rt;
    assign d = (instructions == NOP) ? '0 : {rs_data, rt_data, imm, rs, rt, rd,
        PC_W'(pc_FETCH + instructions[PC_W-1:0]), instructions[PC_W-1:0],
        rs_data[PC_W-1:0], PC_W'(pc_FETCH - PC_W'(1)), ctrl_out, alu_out};
    always_ff @(posedge clk) begin
        if (rst || pc_src_EX != 2'b00)
            q <= '0;
        else if (!stall_EX)
            q <= d;
    end
    assign {rs_data_DEC, rt_data_DEC, imm_DEC, rs_DEC, rt_DEC, rd_DEC, branch_addr_DEC,
            jtype_addr_DEC, reg_addr_DEC, pc_link_DEC, ctrl_DEC, alu_op_DEC} = q;
endmodule
